// File: rtl/skolem_pkg.sv
// Shared definitions for the Skolem truth-table sweep harness and the
// wrapper that instantiates the generated Skolem netlist.
package skolem_pkg;

    // Default Skolem block shape; the netlist wrapper uses the same values.
    localparam int N_IN_DEF = 8;
    localparam int W_DEF    = 32;

    // Words per sweep and word-address width for the default shape.
    localparam int NWORDS = (1 << N_IN_DEF) / W_DEF;
    localparam int AW     = N_IN_DEF - $clog2(W_DEF);

    // state | meaning
    // IDLE  | waiting for start
    // DRIVE | vec_o just presented, latency counter loaded
    // WAIT  | counting down the Skolem latency, sample fn_i at zero
    // EMIT  | truth-table word offered on tt_*, waiting for tt_ready
    // FIN   | one-cycle done pulse after the last word
    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        WAIT,
        EMIT,
        FIN
    } state_t;

    // Word-address width for an arbitrary (N_IN, W) pair.
    function automatic int addr_width(input int n_in, input int w);
        return n_in - $clog2(w);
    endfunction

endpackage

// File: rtl/tt_packer.sv
// Truth-table word assembly: inserts one sampled bit per vector at its
// bit position and latches the finished word for the output stage.
module tt_packer #(
    parameter int W  = 32,
    parameter int IW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          ins,
    input  logic [IW-1:0] idx,
    input  logic          din,
    input  logic          last,
    output logic [W-1:0]  word
);

    logic [W-1:0] sreg;
    logic [W-1:0] merged;

    // Current partial word with the incoming bit already inserted.
    always_comb begin
        merged      = sreg;
        merged[idx] = din;
    end

    // Accumulate bits; on the final bit of a word copy it to the output register.
    // Every bit of the next word is overwritten, so no clear is needed between words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            word <= '0;
        end else if (clr) begin
            sreg <= '0;
            word <= '0;
        end else if (ins) begin
            sreg <= merged;
            if (last) begin
                word <= merged;
            end
        end
    end

endmodule

// File: rtl/skolem_tt_sweep.sv
// Exhaustive input sweep for a combinational Skolem block: drives every
// assignment, samples the returned bit after the glue latency, packs the
// results into truth-table words and streams them out over valid/ready.
module skolem_tt_sweep
    import skolem_pkg::*;
#(
    parameter int N_IN = N_IN_DEF,
    parameter int W    = W_DEF,
    parameter int LAT  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    output logic [N_IN-1:0]               vec_o,
    input  logic                          fn_i,
    output logic [W-1:0]                  tt_data,
    output logic [addr_width(N_IN,W)-1:0] tt_addr,
    output logic                          tt_valid,
    input  logic                          tt_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          aborted,
    output logic [N_IN:0]                 ones_cnt
);

    localparam int LW  = $clog2(W);
    localparam int TAW = addr_width(N_IN, W);

    localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
    localparam logic [TAW-1:0]  ADDR_ONE  = TAW'(1);
    localparam logic [2:0]      WAIT_LOAD = 3'(LAT - 1);

    state_t        state;
    logic [2:0]    wait_cnt;
    logic [LW-1:0] bit_idx;
    logic          sample;
    logic          word_end;
    logic          pk_clr;

    // Bit position within the current word is the low part of the vector.
    assign bit_idx  = vec_o[LW-1:0];
    assign word_end = &bit_idx;
    assign sample   = (state == WAIT) && (wait_cnt == 3'd0) && !abort;
    assign pk_clr   = (state == IDLE) && start;

    tt_packer #(
        .W  (W),
        .IW (LW)
    ) u_packer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pk_clr),
        .ins   (sample),
        .idx   (bit_idx),
        .din   (fn_i),
        .last  (word_end),
        .word  (tt_data)
    );

    // Sweep sequencer: vector stepping, latency wait, word handshake, abort.
    // busy is high exactly in DRIVE/WAIT/EMIT, so it doubles as the abort qualifier.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
            vec_o    <= '0;
            tt_addr  <= '0;
            tt_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            ones_cnt <= '0;
        end else if (abort && busy) begin
            state    <= IDLE;
            tt_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            aborted  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= DRIVE;
                        ones_cnt <= '0;
                        aborted  <= 1'b0;
                        tt_addr  <= '0;
                        vec_o    <= '0;
                        busy     <= 1'b1;
                    end
                end
                DRIVE: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end else begin
                        ones_cnt <= ones_cnt + {{N_IN{1'b0}}, fn_i};
                        if (word_end) begin
                            state    <= EMIT;
                            tt_valid <= 1'b1;
                        end else begin
                            vec_o <= vec_o + VEC_ONE;
                            state <= DRIVE;
                        end
                    end
                end
                EMIT: begin
                    if (tt_ready) begin
                        tt_valid <= 1'b0;
                        if (&vec_o) begin
                            state <= FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            tt_addr <= tt_addr + ADDR_ONE;
                            vec_o   <= vec_o + VEC_ONE;
                            state   <= DRIVE;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skolem_tt_sweep.sv
// Bench for skolem_tt_sweep: a LAT=1 instance exercised with several Skolem
// functions, stalls, abort and reset, plus a LAT=3 instance fed through a
// three-stage delay to show sampling honours the latency.
module tb_skolem_tt_sweep;
    import skolem_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // LAT=1 instance
    logic        start1, abort1, ready1, fn1;
    logic [7:0]  vec1;
    logic [31:0] data1;
    logic [2:0]  addr1;
    logic        valid1, busy1, done1, aborted1;
    logic [8:0]  ones1;

    // LAT=3 instance
    logic        start3, fn3;
    logic [7:0]  vec3;
    logic [31:0] data3;
    logic [2:0]  addr3;
    logic        valid3, busy3, done3, aborted3;
    logic [8:0]  ones3;
    logic [2:0]  pipe3;

    skolem_tt_sweep #(.N_IN(8), .W(32), .LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
        .vec_o(vec1), .fn_i(fn1), .tt_data(data1), .tt_addr(addr1),
        .tt_valid(valid1), .tt_ready(ready1), .busy(busy1), .done(done1),
        .aborted(aborted1), .ones_cnt(ones1)
    );

    skolem_tt_sweep #(.N_IN(8), .W(32), .LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(1'b0),
        .vec_o(vec3), .fn_i(fn3), .tt_data(data3), .tt_addr(addr3),
        .tt_valid(valid3), .tt_ready(1'b1), .busy(busy3), .done(done3),
        .aborted(aborted3), .ones_cnt(ones3)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Skolem function models
    int mode1 = 0;
    bit rtab [256];

    function automatic logic fmodel(input int mode, input logic [7:0] v);
        case (mode)
            0:       return 1'b0;
            1:       return v[0];
            2:       return &v;
            3:       return v[1];
            default: return rtab[v];
        endcase
    endfunction

    assign fn1 = fmodel(mode1, vec1);

    // Three register stages between vec3 and fn3 model the glue latency.
    always @(posedge clk) pipe3 <= {pipe3[1:0], vec3[1]};
    assign fn3 = pipe3[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t q1[$];
    exp_t q3[$];

    int   ndone1 = 0;
    int   vseq_err = 0;
    logic [7:0] pvec1 = '0;
    logic pbusy1 = 1'b0;

    // Scoreboard and sequence monitor for the LAT=1 instance.
    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n) begin
            if (valid1 && ready1 && !abort1) begin
                if (q1.size() == 0) begin
                    chk("sb1_unexpected_word", {61'd0, addr1}, 64'hFFFF);
                end else begin
                    e = q1.pop_front();
                    chk("sb1_addr", {61'd0, addr1}, {61'd0, e.a});
                    chk("sb1_data", {32'd0, data1}, {32'd0, e.d});
                end
            end
            if (done1) ndone1 <= ndone1 + 1;
            if (busy1 && pbusy1 && vec1 != pvec1 && vec1 != pvec1 + 8'd1)
                vseq_err <= vseq_err + 1;
        end
        pvec1  <= vec1;
        pbusy1 <= busy1;
    end

    // Scoreboard for the LAT=3 instance.
    always @(negedge clk) begin : mon3
        exp_t e;
        if (rst_n && valid3) begin
            if (q3.size() == 0) begin
                chk("sb3_unexpected_word", {61'd0, addr3}, 64'hFFFF);
            end else begin
                e = q3.pop_front();
                chk("sb3_addr", {61'd0, addr3}, {61'd0, e.a});
                chk("sb3_data", {32'd0, data3}, {32'd0, e.d});
            end
        end
    end

    int exp_ones;

    task automatic push_words(input int mode, input int nwords);
        exp_t e;
        exp_ones = 0;
        for (int j = 0; j < nwords; j++) begin
            e.a = 3'(j);
            e.d = '0;
            for (int k = 0; k < 32; k++) begin
                e.d[k] = fmodel(mode, 8'(j * 32 + k));
                exp_ones += int'(e.d[k]);
            end
            q1.push_back(e);
        end
    endtask

    task automatic pulse1();
        @(posedge clk);
        #1 start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
    endtask

    task automatic wait_done1(input string tag, input int budget);
        int n = 0;
        while (!done1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {63'd0, done1}, 64'd1);
    endtask

    task automatic wait_vec1(input logic [7:0] v, input int budget);
        int n = 0;
        while (vec1 != v && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_vec", {56'd0, vec1}, {56'd0, v});
    endtask

    task automatic wait_valid1(input int budget);
        int n = 0;
        while (!valid1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_valid", {63'd0, valid1}, 64'd1);
    endtask

    task automatic run_full(input string tag, input int mode, input bit restart_mid);
        int d0, s0;
        d0 = ndone1;
        s0 = vseq_err;
        mode1 = mode;
        push_words(mode, 8);
        pulse1();
        if (restart_mid) begin
            repeat (200) @(negedge clk);
            pulse1();
        end
        wait_done1({tag, "_done"}, 3000);
        repeat (3) @(negedge clk);
        chk({tag, "_ones"}, {55'd0, ones1}, 64'(exp_ones));
        chk({tag, "_aborted"}, {63'd0, aborted1}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy1}, 64'd0);
        chk({tag, "_ndone"}, 64'(ndone1 - d0), 64'd1);
        chk({tag, "_vseq"}, 64'(vseq_err - s0), 64'd0);
        chk({tag, "_sb_empty"}, 64'(q1.size()), 64'd0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_dut1"}, {8'd0, vec1, data1, addr1, valid1, busy1, done1, aborted1, ones1}, 64'd0);
        chk({tag, "_dut3"}, {8'd0, vec3, data3, addr3, valid3, busy3, done3, aborted3, ones3}, 64'd0);
    endtask

    initial begin
        int d0, t0, n;
        start1 = 1'b0;
        abort1 = 1'b0;
        ready1 = 1'b1;
        start3 = 1'b0;
        foreach (rtab[i]) rtab[i] = 1'($urandom_range(0, 1));

        #23;
        check_reset("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // fn tied 0, alternating, single-minterm and random functions
        run_full("zero", 0, 1'b0);
        chk("zero_ones_const", {55'd0, ones1}, 64'd0);
        run_full("alt", 1, 1'b0);
        chk("alt_ones_const", {55'd0, ones1}, 64'd128);
        run_full("and", 2, 1'b0);
        chk("and_ones_const", {55'd0, ones1}, 64'd1);
        run_full("rand", 4, 1'b0);

        // start pulsed while busy must not restart the sweep
        run_full("restart", 1, 1'b1);

        // downstream stall on word 2
        d0 = ndone1;
        mode1 = 1;
        push_words(1, 8);
        pulse1();
        wait_vec1(8'd95, 1000);
        ready1 = 1'b0;
        wait_valid1(20);
        repeat (10) begin
            @(negedge clk);
            chk("stall_hold", {20'd0, valid1, addr1, vec1, data1},
                {20'd0, 1'b1, 3'd2, 8'd95, 32'hAAAA_AAAA});
        end
        ready1 = 1'b1;
        wait_done1("stall_done", 3000);
        repeat (3) @(negedge clk);
        chk("stall_ndone", 64'(ndone1 - d0), 64'd1);
        chk("stall_sb_empty", 64'(q1.size()), 64'd0);

        // abort coinciding with the word 4 handshake
        d0 = ndone1;
        push_words(1, 4);
        pulse1();
        wait_vec1(8'd159, 1000);
        ready1 = 1'b0;
        wait_valid1(20);
        chk("abort_addr", {61'd0, addr1}, 64'd4);
        abort1 = 1'b1;
        ready1 = 1'b1;
        @(posedge clk);
        #1 abort1 = 1'b0;
        @(negedge clk);
        chk("abort_state", {59'd0, valid1, aborted1, busy1, done1},
            {59'd0, 1'b0, 1'b1, 1'b0, 1'b1});
        chk("abort_ones", {55'd0, ones1}, 64'd80);
        repeat (3) @(negedge clk);
        chk("abort_ndone", 64'(ndone1 - d0), 64'd1);
        chk("abort_sb_empty", 64'(q1.size()), 64'd0);
        chk("abort_sticky", {63'd0, aborted1}, 64'd1);
        run_full("after_abort", 2, 1'b0);

        // LAT=3 instance: latency honoured and sweep time
        for (int j = 0; j < 8; j++) q3.push_back('{a: 3'(j), d: 32'hCCCC_CCCC});
        @(posedge clk);
        #1 start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        t0 = cyc;
        n = 0;
        while (!done3 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("lat3_done", {63'd0, done3}, 64'd1);
        // edges from the one capturing start through the one raising done
        chk("lat3_cycles", 64'(cyc - t0 + 1), 64'(256 * 4 + 8 + 1));
        chk("lat3_ones", {55'd0, ones3}, 64'd128);
        repeat (3) @(negedge clk);
        chk("lat3_sb_empty", 64'(q3.size()), 64'd0);

        // asynchronous reset in the middle of a sweep
        mode1 = 1;
        push_words(1, 8);
        pulse1();
        repeat (150) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset("midreset");
        q1.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        run_full("after_reset", 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
